// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio output path.
package audio_pkg;

    localparam int unsigned SAMPLE_W_DEF = 16;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } stereo_t;

    typedef enum logic {PRIME, RUN} buf_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy tracking; no bypass from push to pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       input_clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge input_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge input_clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/i2s_sample_buffer.sv
// Stereo sample buffer feeding the I2S serializer: FIFO plus a priming FSM that
// keeps output silent until enough pairs are queued and handles underruns.
module i2s_sample_buffer
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W     = SAMPLE_W_DEF,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned PRIME_LEVEL  = 4,
    parameter int unsigned UNDERRUN_REP = 0
) (
    input  logic                       input_clk,
    input  logic                       reset,
    input  logic [SAMPLE_W-1:0]        in_left,
    input  logic [SAMPLE_W-1:0]        in_right,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       frame_req,
    output logic [SAMPLE_W-1:0]        out_left,
    output logic [SAMPLE_W-1:0]        out_right,
    output logic                       out_update,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun,
    output logic [15:0]                underrun_cnt,
    input  logic                       clear_status
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned PAIR_W = 2 * SAMPLE_W;

    buf_state_t        state_q;
    buf_state_t        state_d;
    logic              full;
    logic              empty;
    logic              pop_en;
    logic              underrun_ev;
    logic [PAIR_W-1:0] fifo_data;
    logic [PAIR_W-1:0] out_q;
    logic [PAIR_W-1:0] last_q;
    logic              out_update_q;
    logic              underrun_q;
    logic [15:0]       underrun_cnt_q;

    assign in_ready = !full && !reset;

    sync_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .input_clk (input_clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data ({in_left, in_right}),
        .pop       (pop_en),
        .pop_data  (fifo_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge input_clk) begin
        if (reset) state_q <= PRIME;
        else       state_q <= state_d;
    end

    // A frame_req arriving on the PRIME->RUN edge is still served as PRIME.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PRIME: if (level >= LVL_W'(PRIME_LEVEL)) state_d = RUN;
            RUN:   if (frame_req && empty)           state_d = PRIME;
            default: state_d = PRIME;
        endcase
    end

    always_comb begin
        pop_en      = 1'b0;
        underrun_ev = 1'b0;
        if (state_q == RUN && frame_req) begin
            pop_en      = !empty;
            underrun_ev = empty;
        end
    end

    always_ff @(posedge input_clk) begin
        if (reset) begin
            out_q        <= '0;
            last_q       <= '0;
            out_update_q <= 1'b0;
        end else begin
            out_update_q <= frame_req;
            if (frame_req) begin
                if (pop_en)                                out_q <= fifo_data;
                else if (underrun_ev && UNDERRUN_REP != 0) out_q <= last_q;
                else                                       out_q <= '0;
            end
            if (pop_en) last_q <= fifo_data;
        end
    end

    // An underrun in the same cycle as clear_status wins and restarts the count at one.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else if (underrun_ev) begin
            underrun_q     <= 1'b1;
            underrun_cnt_q <= clear_status ? 16'd1 : sat_inc16(underrun_cnt_q);
        end else if (clear_status) begin
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end
    end

    assign out_left     = out_q[PAIR_W-1:SAMPLE_W];
    assign out_right    = out_q[SAMPLE_W-1:0];
    assign out_update   = out_update_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_sample_buffer.sv
// Randomised bench for i2s_sample_buffer: queue-based reference model plus an
// output scoreboard that pairs every frame request with one output update.
module tb_i2s_sample_buffer;
    import audio_pkg::*;

    localparam int unsigned DEPTH        = 8;
    localparam int unsigned PRIME_LEVEL  = 4;
    localparam int unsigned UNDERRUN_REP = 0;

    logic        input_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        frame_req = 1'b0;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_update;
    logic [3:0]  level;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        clear_status = 1'b0;

    int checks = 0;
    int errors = 0;

    i2s_sample_buffer #(
        .SAMPLE_W     (16),
        .DEPTH        (DEPTH),
        .PRIME_LEVEL  (PRIME_LEVEL),
        .UNDERRUN_REP (UNDERRUN_REP)
    ) dut (
        .input_clk    (input_clk),
        .reset        (reset),
        .in_left      (in_left),
        .in_right     (in_right),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frame_req    (frame_req),
        .out_left     (out_left),
        .out_right    (out_right),
        .out_update   (out_update),
        .level        (level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .clear_status (clear_status)
    );

    always #5 input_clk = ~input_clk;

    // Reference model state
    stereo_t mq[$];
    stereo_t expq[$];
    stereo_t m_out;
    stereo_t m_last;
    bit      running;
    bit      m_flag;
    int      m_cnt;
    bit      was_run;
    bit      und;
    int      sz;

    always @(posedge input_clk) begin
        if (reset) begin
            mq.delete();
            running = 1'b0;
            m_flag  = 1'b0;
            m_cnt   = 0;
            m_last  = '0;
            m_out   = '0;
        end else begin
            was_run = running;
            sz      = mq.size();
            und     = 1'b0;
            if (frame_req) begin
                if (!was_run) begin
                    m_out = '0;
                end else if (sz > 0) begin
                    m_out  = mq.pop_front();
                    m_last = m_out;
                end else begin
                    und   = 1'b1;
                    m_out = (UNDERRUN_REP != 0) ? m_last : '0;
                end
                expq.push_back(m_out);
            end
            if (in_valid && sz < int'(DEPTH)) mq.push_back({in_left, in_right});
            if (!was_run && sz >= int'(PRIME_LEVEL)) running = 1'b1;
            else if (und)                          running = 1'b0;
            if (und) begin
                m_flag = 1'b1;
                m_cnt  = clear_status ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
            end else if (clear_status) begin
                m_flag = 1'b0;
                m_cnt  = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and scoreboard, sampled just after each active edge.
    stereo_t exp_pair;
    always begin
        @(posedge input_clk);
        #1;
        chk("level", 32'(level), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(!reset && mq.size() < int'(DEPTH)));
        chk("underrun", 32'(underrun), 32'(m_flag));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
        chk("out_held", {out_left, out_right}, m_out);
        if (out_update) begin
            if (expq.size() == 0) begin
                chk("spurious_update", 32'(out_update), 32'd0);
            end else begin
                exp_pair = expq.pop_front();
                chk("update_pair", {out_left, out_right}, exp_pair);
            end
        end else if (expq.size() != 0) begin
            chk("missing_update", 32'(out_update), 32'd1);
            expq.delete();
        end
    end

    task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r,
                        input bit f, input bit c, input bit rs);
        @(negedge input_clk);
        in_valid     = v;
        in_left      = l;
        in_right     = r;
        frame_req    = f;
        clear_status = c;
        reset        = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_rand();
        step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame();
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // Priming: three pairs, frame yields silence
        for (int i = 0; i < 3; i++) push_rand();
        frame();
        idle(1);
        step(1'b1, 16'h7D00, 16'h8300, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            frame();
            idle(2);
        end
        // Underrun at level 0 in RUN
        frame();
        idle(2);
        // Fill to full with valid held, then pop while valid is still offered
        for (int i = 0; i < 12; i++) push_rand();
        step(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 7; i++) begin
            frame();
            idle(1);
        end
        // Push and pop together at level 0 in RUN
        step(1'b1, 16'h0A0A, 16'h0B0B, 1'b1, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) push_rand();
        idle(2);
        frame();
        idle(1);
        // Push and pop together at level 3 in RUN
        step(1'b1, 16'h0C0C, 16'h0D0D, 1'b1, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) frame();
        // Underrun together with clear_status
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        idle(2);
        // Reset at level 5
        for (int i = 0; i < 5; i++) push_rand();
        idle(1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(2);
        frame();
        idle(1);

        // Random phases with varying producer and consumer rates
        for (int p = 0; p < 12; p++) begin
            automatic int pv = (p % 3 == 0) ? 20 : (p % 3 == 1) ? 50 : 90;
            automatic int pf = (p % 4 == 0) ? 10 : (p % 4 == 1) ? 30 : (p % 4 == 2) ? 60 : 45;
            for (int i = 0; i < 300; i++) begin
                automatic bit rs = ($urandom_range(0, 499) == 0);
                step(($urandom_range(0, 99) < pv), 16'($urandom), 16'($urandom),
                     !rs && ($urandom_range(0, 99) < pf),
                     ($urandom_range(0, 99) == 0), rs);
            end
        end
        idle(3);
        chk("pending_updates", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
